// File: rtl/win_pkg.sv
// Shared types and constants for the light-grid win detector: FSM states,
// win-kind codes, mode_mask bit positions and the alternating-phase pattern.
package win_pkg;

  typedef enum logic [1:0] {
    ST_MIXING  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_WON     = 2'd3
  } win_state_e;

  localparam logic [2:0] KIND_NONE   = 3'd0;
  localparam logic [2:0] KIND_ZEROS  = 3'd1;
  localparam logic [2:0] KIND_ONES   = 3'd2;
  localparam logic [2:0] KIND_ALT_A  = 3'd3;
  localparam logic [2:0] KIND_ALT_B  = 3'd4;
  localparam logic [2:0] KIND_TARGET = 3'd5;

  localparam int unsigned MODE_ZEROS  = 0;
  localparam int unsigned MODE_ONES   = 1;
  localparam int unsigned MODE_ALT_A  = 2;
  localparam int unsigned MODE_ALT_B  = 3;
  localparam int unsigned MODE_TARGET = 4;
  localparam int unsigned MODE_W      = 5;

  localparam int unsigned ALT_MAX_W = 1024;

  // Phase A alternating pattern: even bits set, bit 0 = 1; callers truncate to their width.
  function automatic logic [ALT_MAX_W-1:0] alt_pattern(int unsigned width);
    logic [ALT_MAX_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < ALT_MAX_W; i++) begin
      p[i] = (i < width) && ((i % 2) == 0);
    end
    return p;
  endfunction

endpackage

// File: rtl/win_pattern_match.sv
// Combinational board classifier: flags any enabled winning pattern and
// reports the lowest-index match as a win-kind code.
module win_pattern_match
  import win_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]  screen,
  input  logic [WIDTH-1:0]  target,
  input  logic [MODE_W-1:0] mode_mask,
  output logic              any_match,
  output logic [2:0]        kind
);

  localparam logic [WIDTH-1:0] ALT_A = WIDTH'(alt_pattern(WIDTH));

  logic [MODE_W-1:0] hit;
  logic [MODE_W-1:0] hits;

  // Kind codes are mode index + 1, so a descending scan leaves the lowest index.
  always_comb begin
    hit              = '0;
    hit[MODE_ZEROS]  = (screen == '0);
    hit[MODE_ONES]   = (screen == '1);
    hit[MODE_ALT_A]  = (screen == ALT_A);
    hit[MODE_ALT_B]  = (screen == ~ALT_A);
    hit[MODE_TARGET] = (screen == target);
    hits             = hit & mode_mask;
    kind             = KIND_NONE;
    for (int i = MODE_W - 1; i >= 0; i--) begin
      if (hits[i]) kind = 3'(i + 1);
    end
  end

  assign any_match = |hits;

endmodule

// File: rtl/win_detector.sv
// End-of-game detector: declares a win once an enabled pattern is held stable,
// then drives a timed buzzer pulse, a sticky win flag and a move counter.
module win_detector
  import win_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned BUZZ_CYCLES   = 50_000_000,
  parameter int unsigned MOVE_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  screen_values,
  input  logic              mix_state,
  input  logic [WIDTH-1:0]  target_pattern,
  input  logic [4:0]        mode_mask,
  output logic              buzz,
  output logic              win,
  output logic [2:0]        win_kind,
  output logic [MOVE_W-1:0] move_count
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned BUZZ_W = $clog2(BUZZ_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES);
  localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES);

  win_state_e        state_q;
  logic [WIDTH-1:0]  snap_q;
  logic [WIDTH-1:0]  prev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BUZZ_W-1:0] buzz_cnt_q;

  logic       any_match_c;
  logic [2:0] kind_c;
  logic       hunting_c;
  logic [CNT_W-1:0] cnt_inc_c;

  win_pattern_match #(.WIDTH(WIDTH)) u_match (
    .screen    (screen_values),
    .target    (target_pattern),
    .mode_mask (mode_mask),
    .any_match (any_match_c),
    .kind      (kind_c)
  );

  assign hunting_c = (state_q == ST_ARMED) || (state_q == ST_CONFIRM);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_MIXING;
      snap_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      buzz_cnt_q <= '0;
      buzz       <= 1'b0;
      win        <= 1'b0;
      win_kind   <= KIND_NONE;
      move_count <= '0;
    end else begin
      prev_q <= screen_values;
      if (mix_state || (state_q == ST_MIXING)) begin
        // Scramble in progress (or just released): wipe everything, no residue.
        state_q    <= mix_state ? ST_MIXING : ST_ARMED;
        snap_q     <= '0;
        cnt_q      <= '0;
        buzz_cnt_q <= '0;
        buzz       <= 1'b0;
        win        <= 1'b0;
        win_kind   <= KIND_NONE;
        move_count <= '0;
      end else begin
        if (hunting_c && (screen_values != prev_q) && (move_count != '1)) begin
          move_count <= move_count + MOVE_W'(1);
        end
        case (state_q)
          ST_ARMED: begin
            if (any_match_c) begin
              snap_q <= screen_values;
              cnt_q  <= CNT_W'(1);
              if (CNT_LAST == CNT_W'(1)) begin
                state_q    <= ST_WON;
                win        <= 1'b1;
                buzz       <= 1'b1;
                win_kind   <= kind_c;
                buzz_cnt_q <= BUZZ_LOAD;
              end else begin
                state_q <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (any_match_c && (screen_values == snap_q)) begin
              cnt_q <= cnt_inc_c;
              if (cnt_inc_c == CNT_LAST) begin
                state_q    <= ST_WON;
                win        <= 1'b1;
                buzz       <= 1'b1;
                win_kind   <= kind_c;
                buzz_cnt_q <= BUZZ_LOAD;
              end
            end else if (any_match_c) begin
              snap_q <= screen_values;
              cnt_q  <= CNT_W'(1);
            end else begin
              state_q <= ST_ARMED;
              cnt_q   <= '0;
            end
          end
          ST_WON: begin
            // Counter holds remaining high cycles including the current one.
            if (buzz_cnt_q != '0) buzz_cnt_q <= buzz_cnt_q - BUZZ_W'(1);
            buzz <= (buzz_cnt_q > BUZZ_W'(1));
          end
          default: state_q <= ST_MIXING;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_win_detector.sv
// Self-checking bench for win_detector: history-based reference model checked
// every cycle, plus directed literal expectations.
module tb_win_detector;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = 4;
  localparam int unsigned B     = 8;
  localparam int unsigned MW    = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] screen_values;
  logic             mix_state;
  logic [WIDTH-1:0] target_pattern;
  logic [4:0]       mode_mask;

  logic          buzz, win;
  logic [2:0]    win_kind;
  logic [MW-1:0] move_count;
  logic          buzz1, win1;
  logic [2:0]    win_kind1;
  logic [MW-1:0] move_count1;

  int checks = 0;
  int errors = 0;

  win_detector #(.WIDTH(WIDTH), .STABLE_CYCLES(N), .BUZZ_CYCLES(B), .MOVE_W(MW)) dut (
    .clk(clk), .reset_n(reset_n), .screen_values(screen_values), .mix_state(mix_state),
    .target_pattern(target_pattern), .mode_mask(mode_mask),
    .buzz(buzz), .win(win), .win_kind(win_kind), .move_count(move_count)
  );

  win_detector #(.WIDTH(WIDTH), .STABLE_CYCLES(1), .BUZZ_CYCLES(B), .MOVE_W(MW)) dut1 (
    .clk(clk), .reset_n(reset_n), .screen_values(screen_values), .mix_state(mix_state),
    .target_pattern(target_pattern), .mode_mask(mode_mask),
    .buzz(buzz1), .win(win1), .win_kind(win_kind1), .move_count(move_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: classify each sample straight from the pattern rules.
  function automatic logic [2:0] classify(input logic [31:0] s, input logic [31:0] t,
                                          input logic [4:0] m);
    if (m[0] && s == 32'h0000_0000) return 3'd1;
    if (m[1] && s == 32'hFFFF_FFFF) return 3'd2;
    if (m[2] && s == 32'h5555_5555) return 3'd3;
    if (m[3] && s == 32'hAAAA_AAAA) return 3'd4;
    if (m[4] && s == t)             return 3'd5;
    return 3'd0;
  endfunction

  typedef struct {
    logic [31:0] v;
    bit          m;
  } samp_t;

  samp_t       hist[$];
  bit          m_mixing;
  bit          m_won;
  logic [2:0]  m_kind;
  int          m_buzz_left;
  int          m_moves;
  logic [31:0] m_prev;

  // Win = the last N samples since release all matched and were identical.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      m_mixing = 1'b1; m_won = 1'b0; m_kind = 3'd0;
      m_buzz_left = 0; m_moves = 0; m_prev = '0;
    end else begin
      if (mix_state || m_mixing) begin
        hist.delete();
        m_mixing = mix_state; m_won = 1'b0; m_kind = 3'd0;
        m_buzz_left = 0; m_moves = 0;
      end else if (m_won) begin
        if (m_buzz_left > 0) m_buzz_left--;
      end else begin
        logic [2:0] k;
        int streak;
        if (screen_values != m_prev && m_moves < (2 ** MW) - 1) m_moves++;
        k = classify(screen_values, target_pattern, mode_mask);
        hist.push_back('{v: screen_values, m: (k != 3'd0)});
        streak = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
          if (hist[i].m && hist[i].v == screen_values) streak++;
          else break;
        end
        if (streak >= N) begin
          m_won = 1'b1; m_kind = k; m_buzz_left = B;
        end
      end
      m_prev = screen_values;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_win", 32'(win), 32'(m_won));
    chk("m_buzz", 32'(buzz), 32'(m_buzz_left > 0));
    chk("m_moves", 32'(move_count), 32'(m_moves));
    if (m_won) chk("m_kind", 32'(win_kind), 32'(m_kind));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hi;
    reset_n = 1'b0; mix_state = 1'b1; screen_values = '0;
    target_pattern = '0; mode_mask = '0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("rst_release_win", 32'(win), 32'd0);

    // All-zeros win after 4 samples; buzz 8 cycles while board keeps changing.
    mix_state = 1'b0; mode_mask = 5'b11111; screen_values = 32'h0000_1234;
    tick(1);
    screen_values = 32'h0;
    tick(3);
    chk("zeros_early_win", 32'(win), 32'd0);
    tick(1);
    chk("zeros_win", 32'(win), 32'd1);
    chk("zeros_kind", 32'(win_kind), 32'd1);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (buzz) hi++;
      screen_values = 32'(i + 100);
      tick(1);
    end
    chk("buzz_len", 32'(hi), 32'd8);
    chk("win_sticky", 32'(win), 32'd1);

    // altA with a one-sample glitch.
    mix_state = 1'b1; tick(1);
    mix_state = 1'b0; tick(1);
    screen_values = 32'h5555_5555; tick(3);
    chk("alt_pre_glitch", 32'(win), 32'd0);
    screen_values = 32'h5555_5554; tick(1);
    screen_values = 32'h5555_5555; tick(3);
    chk("alt_3_after", 32'(win), 32'd0);
    tick(1);
    chk("alt_win", 32'(win), 32'd1);
    chk("alt_kind", 32'(win_kind), 32'd3);

    // Asynchronous reset mid-run.
    #2 reset_n = 1'b0; mix_state = 1'b1;
    #1;
    chk("arst_buzz", 32'(buzz), 32'd0);
    chk("arst_win", 32'(win), 32'd0);
    chk("arst_kind", 32'(win_kind), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2);
    chk("arst_mix_win", 32'(win), 32'd0);

    // Target only: all-ones must not win.
    mix_state = 1'b0; target_pattern = 32'hDEAD_BEEF; mode_mask = 5'b10000; tick(1);
    screen_values = 32'hFFFF_FFFF; tick(10);
    chk("ones_masked", 32'(win), 32'd0);
    screen_values = 32'hDEAD_BEEF; tick(4);
    chk("target_win", 32'(win), 32'd1);
    chk("target_kind", 32'(win_kind), 32'd5);

    // Move counter saturation, then clear on mix.
    mix_state = 1'b1; tick(1);
    mix_state = 1'b0; mode_mask = 5'b00000; tick(1);
    for (int i = 1; i <= 20; i++) begin
      screen_values = 32'(i * 7 + 1);
      tick(1);
    end
    chk("moves_sat", 32'(move_count), 32'd15);
    mix_state = 1'b1; tick(1);
    chk("moves_clr", 32'(move_count), 32'd0);

    // Mix mid-CONFIRM leaves no residue.
    mix_state = 1'b0; mode_mask = 5'b11111; screen_values = 32'h0000_0F0F; tick(1);
    screen_values = 32'hFFFF_FFFF; tick(2);
    mix_state = 1'b1; tick(1);
    mix_state = 1'b0; tick(2);
    chk("confirm_abort", 32'(win), 32'd0);

    // Mix during buzz cycle 3.
    screen_values = 32'hAAAA_AAAA; tick(4);
    chk("altb_kind", 32'(win_kind), 32'd4);
    tick(2);
    chk("buzz_c3", 32'(buzz), 32'd1);
    mix_state = 1'b1; tick(1);
    chk("mix_buzz", 32'(buzz), 32'd0);
    chk("mix_win", 32'(win), 32'd0);

    // Single-sample build: win right after one matching edge.
    mix_state = 1'b0; screen_values = 32'h0000_1111; tick(1);
    chk("s1_idle", 32'(win1), 32'd0);
    screen_values = 32'h0; tick(1);
    chk("s1_win", 32'(win1), 32'd1);
    chk("s1_kind", 32'(win_kind1), 32'd1);
    chk("s1_buzz", 32'(buzz1), 32'd1);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
